// File: rtl/leaf_user_in_fifo.sv
// leaf_user_in_fifo: elastic buffer between the leaf interface's data/vld/ack
// output and the user kernel. The words are held in a small memory plus a registered
// output stage, and the block keeps a running count of the words it has accepted.
module leaf_user_in_fifo #(
    parameter int unsigned PAYLOAD_BITS = 32,
    parameter int unsigned DEPTH_BITS   = 4,
    parameter int unsigned AF_MARGIN    = 1
) (
    input  logic                    clk_user,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
    input  logic                    vld_interface2user,
    output logic                    ack_user2interface,
    output logic [PAYLOAD_BITS-1:0] m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DEPTH_BITS:0]     occupancy,
    output logic [31:0]             rx_count
);

    localparam int unsigned Depth    = 2 ** DEPTH_BITS;
    // The output register holds one word, so the memory needs one slot fewer.
    localparam int unsigned MemSlots = Depth - 1;

    typedef logic [DEPTH_BITS:0]   cnt_t;
    typedef logic [DEPTH_BITS-1:0] ptr_t;

    localparam cnt_t AckLimit = cnt_t'(Depth - AF_MARGIN);
    localparam ptr_t LastSlot = ptr_t'(MemSlots - 1);

    logic [PAYLOAD_BITS-1:0] mem [MemSlots];

    logic                    ack_q, ack_d;
    logic                    tvalid_q, tvalid_d;
    logic [PAYLOAD_BITS-1:0] tdata_q, tdata_d;
    cnt_t                    occ_q, occ_d;
    logic [31:0]             rx_q, rx_d;
    ptr_t                    wr_ptr_q, wr_ptr_d;
    ptr_t                    rd_ptr_q, rd_ptr_d;

    logic push, pop, mem_empty, bypass, mem_wr, mem_rd;
    cnt_t mem_cnt;

    // Transfer decode: where each pushed word goes and whether memory feeds the output.
    always_comb begin
        push      = vld_interface2user && ack_q;
        pop       = tvalid_q && m_tready;
        mem_cnt   = occ_q - cnt_t'(tvalid_q);
        mem_empty = (mem_cnt == '0);
        // A word may skip memory only if nothing older is queued ahead of it.
        bypass    = push && (!tvalid_q || (pop && mem_empty));
        mem_wr    = push && !bypass;
        mem_rd    = pop && !mem_empty;
    end

    // Next-state for output stage, pointers, occupancy, ack and statistic.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (pop) begin
            tvalid_d = mem_rd || bypass;
        end else if (bypass) begin
            tvalid_d = 1'b1;
        end

        if (bypass) begin
            tdata_d = dout_leaf_interface2user;
        end else if (mem_rd) begin
            tdata_d = mem[rd_ptr_q];
        end

        if (mem_wr) begin
            wr_ptr_d = (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + ptr_t'(1);
        end
        if (mem_rd) begin
            rd_ptr_d = (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + ptr_t'(1);
        end

        occ_d = occ_q + cnt_t'(push) - cnt_t'(pop);
        // Ack looks at next occupancy so a push can never land on a full block.
        ack_d = (occ_d < AckLimit);
        rx_d  = rx_q + 32'(push);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_user) begin
        if (reset) begin
            ack_q    <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            occ_q    <= '0;
            rx_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            ack_q    <= ack_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            occ_q    <= occ_d;
            rx_q     <= rx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care after reset so it is not cleared.
    always_ff @(posedge clk_user) begin
        if (!reset && mem_wr) begin
            mem[wr_ptr_q] <= dout_leaf_interface2user;
        end
    end

    assign ack_user2interface = ack_q;
    assign m_tvalid           = tvalid_q;
    assign m_tdata            = tdata_q;
    assign occupancy          = occ_q;
    assign rx_count           = rx_q;

endmodule

// File: tb/tb_leaf_user_in_fifo.sv
// Bench for leaf_user_in_fifo: queue-based reference model compared every cycle,
// plus directed sequences with literal expectations.
module tb_leaf_user_in_fifo;

    localparam int PB        = 32;
    localparam int DB        = 4;
    localparam int DEPTH     = 16;
    localparam int AF_MARGIN = 1;

    logic          clk_user = 1'b0;
    logic          reset    = 1'b1;
    logic [PB-1:0] din      = '0;
    logic          vld      = 1'b0;
    logic          ack;
    logic [PB-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [DB:0]   occupancy;
    logic [31:0]   rx_count;

    int checks = 0;
    int errors = 0;

    leaf_user_in_fifo #(
        .PAYLOAD_BITS(PB),
        .DEPTH_BITS  (DB),
        .AF_MARGIN   (AF_MARGIN)
    ) dut (
        .clk_user                (clk_user),
        .reset                   (reset),
        .dout_leaf_interface2user(din),
        .vld_interface2user      (vld),
        .ack_user2interface      (ack),
        .m_tdata                 (m_tdata),
        .m_tvalid                (m_tvalid),
        .m_tready                (m_tready),
        .occupancy               (occupancy),
        .rx_count                (rx_count)
    );

    always #5 clk_user = ~clk_user;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the block is an ordered list of accepted words, nothing more.
    logic [PB-1:0] model_q[$];
    logic          ack_m   = 1'b0;
    logic [31:0]   rx_m    = '0;
    logic          cmp_en  = 1'b0;
    logic          post_rst = 1'b0;

    always @(posedge clk_user) begin
        bit push_m, pop_m;
        if (reset) begin
            model_q.delete();
            ack_m = 1'b0;
            rx_m  = '0;
        end else begin
            push_m = vld && ack_m;
            pop_m  = (model_q.size() != 0) && m_tready;
            if (pop_m) void'(model_q.pop_front());
            if (push_m) begin
                model_q.push_back(din);
                rx_m = rx_m + 32'd1;
            end
            ack_m = (model_q.size() < DEPTH - AF_MARGIN);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_user) begin
        if (cmp_en) begin
            check("m_ack", 32'(ack), 32'(ack_m));
            check("m_tvalid", 32'(m_tvalid), 32'(model_q.size() != 0));
            check("m_occupancy", 32'(occupancy), 32'(model_q.size()));
            check("m_rx_count", rx_count, rx_m);
            if (model_q.size() != 0) check("m_tdata", m_tdata, model_q[0]);
            if (occupancy > 5'(DEPTH)) check("occ_le_depth", 32'(occupancy), 32'(DEPTH));
            if (occupancy == 5'(DEPTH)) check("no_ack_when_full", 32'(ack), 32'd0);
            if (post_rst && m_tvalid) check("stale_word_tag", 32'(m_tdata[31:28]), 32'hB);
        end
    end

    initial begin
        // Reset then idle.
        repeat (2) @(negedge clk_user);
        cmp_en = 1'b1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_rx", rx_count, 32'd0);
        reset = 1'b0;
        @(negedge clk_user);
        check("ack_after_rst", 32'(ack), 32'd1);
        check("idle_tvalid", 32'(m_tvalid), 32'd0);

        // Single word with the kernel ready.
        din = 32'hDEADBEEF; vld = 1'b1; m_tready = 1'b1;
        @(negedge clk_user);
        vld = 1'b0;
        check("single_tvalid", 32'(m_tvalid), 32'd1);
        check("single_tdata", m_tdata, 32'hDEADBEEF);
        check("single_occ", 32'(occupancy), 32'd1);
        @(negedge clk_user);
        check("single_popped", 32'(m_tvalid), 32'd0);
        check("single_occ0", 32'(occupancy), 32'd0);
        check("single_rx", rx_count, 32'd1);

        // Fill while stalled: 15 words accepted, head stays word 0.
        m_tready = 1'b0; vld = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = 32'(i);
            @(negedge clk_user);
            check("fill_tdata", m_tdata, 32'd0);
        end
        vld = 1'b0;
        check("fill_occ", 32'(occupancy), 32'd15);
        check("fill_ack", 32'(ack), 32'd0);
        check("fill_rx", rx_count, 32'd16);
        check("fill_tvalid", 32'(m_tvalid), 32'd1);

        // Drain in order on consecutive cycles.
        m_tready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            check("drain_tvalid", 32'(m_tvalid), 32'd1);
            check("drain_tdata", m_tdata, 32'(k));
            @(negedge clk_user);
            if (k == 0) check("drain_ack_back", 32'(ack), 32'd1);
        end
        check("drain_empty", 32'(m_tvalid), 32'd0);
        check("drain_occ", 32'(occupancy), 32'd0);

        // Streaming 100 words at full rate after a fresh reset.
        reset = 1'b1;
        @(negedge clk_user);
        reset = 1'b0;
        @(negedge clk_user);
        vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            din = 32'h1000 + 32'(i);
            @(negedge clk_user);
            check("stream_occ", 32'(occupancy), 32'd1);
        end
        vld = 1'b0;
        check("stream_rx", rx_count, 32'd100);
        check("stream_last", m_tdata, 32'h1000 + 32'd99);
        @(negedge clk_user);
        check("stream_drained", 32'(occupancy), 32'd0);

        // Random traffic with a reset pulse in the middle.
        for (int c = 0; c < 10000; c++) begin
            vld      = 1'($urandom_range(0, 1));
            m_tready = 1'($urandom_range(0, 1));
            din      = (c < 5000) ? (32'hA000_0000 | 32'(c)) : (32'hB000_0000 | 32'(c));
            reset    = (c == 5000);
            @(negedge clk_user);
            if (c == 5000) begin
                post_rst = 1'b1;
                check("midrst_occ", 32'(occupancy), 32'd0);
                check("midrst_rx", rx_count, 32'd0);
                check("midrst_tvalid", 32'(m_tvalid), 32'd0);
            end
        end
        reset = 1'b0; vld = 1'b0; m_tready = 1'b1;
        repeat (20) @(negedge clk_user);
        check("final_occ", 32'(occupancy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/leaf_user_in_fifo.md
Name: leaf_user_in_fifo

Overview:
- Per-input-port elastic buffer in the user clock domain.
- Sits directly downstream of the leaf interface's user-side output port, i.e. between the interface's data/vld/ack triple and the user kernel.
- Absorbs words from the interface with a registered ack for backpressure.
- Presents them to the kernel as a valid/ready stream with a registered output stage, and keeps an accepted-word statistic.

Parameters:
- PAYLOAD_BITS, 32, width of one data word.
- DEPTH_BITS, 4, log2 of storage depth; DEPTH = 2**DEPTH_BITS words in total, including the output register.
- AF_MARGIN, 1, ack deasserts when occupancy >= DEPTH - AF_MARGIN; legal range 0..DEPTH-1.

Ports:
- clk_user  in  1  user clock; single clock domain.
- reset  in  1  synchronous, active-high.
- dout_leaf_interface2user  in  PAYLOAD_BITS  word offered by the leaf interface.
- vld_interface2user  in  1  word offered is valid.
- ack_user2interface  out  1  block accepts; a transfer occurs on any edge where vld_interface2user && ack_user2interface.
- m_tdata  out  PAYLOAD_BITS  word to the user kernel.
- m_tvalid  out  1  m_tdata valid.
- m_tready  in  1  kernel accepts; pop occurs on any edge where m_tvalid && m_tready.
- occupancy  out  DEPTH_BITS+1  words held, counting the output register.
- rx_count  out  32  total words accepted since reset; wraps modulo 2**32.

Behaviour:
- Reset (synchronous, takes priority over all events in the same cycle):
  - ack_user2interface=0, m_tvalid=0, m_tdata=0, occupancy=0, rx_count=0.
  - Read and write pointers return to 0.
  - Memory contents are don't-care.
  - Reset asserted mid-stream discards all stored words; no partial word survives.
- Registered ack:
  - ack_user2interface is a register loaded every cycle (reset excepted) with (occupancy_next < DEPTH - AF_MARGIN).
  - Its first assertion after reset release is therefore in the cycle following reset deassertion.
  - ack is independent of vld: the block may assert ack with no word offered, and nothing is written in that case.
- Push: on vld && ack the word enters storage and rx_count increments by 1.
  - If the output register is empty, or is being popped this cycle while memory is empty, the word goes straight to m_tdata.
  - Otherwise it is written to memory at wr_ptr, and wr_ptr increments modulo DEPTH-1 memory slots.
- Pop: on m_tvalid && m_tready:
  - If memory is non-empty, m_tdata loads the memory word at rd_ptr, rd_ptr advances, and m_tvalid stays 1.
  - Otherwise m_tvalid goes to 0 unless a push is bypassing into the output register in the same cycle.
- Latency: a word pushed at edge t into an empty block is visible on m_tdata with m_tvalid=1 after edge t (one cycle from the accepting edge). There is no combinational path from vld to m_tvalid or from m_tready to ack.
- Ordering: strict FIFO; words leave in acceptance order.
- Occupancy:
  - occupancy_next = occupancy + push - pop.
  - Simultaneous push and pop leaves occupancy unchanged and preserves order.
  - Push when full is impossible by construction, because ack is derived from occupancy_next.
  - Pop when empty is impossible because m_tvalid=0.
- m_tdata holds its value while m_tvalid && !m_tready (stable under stall). m_tdata is don't-care when m_tvalid=0 but is not required to change.
- Pointer wrap: pointers wrap from the last memory slot to 0 with no bubble.
- Throughput: sustains 1 word/cycle indefinitely when m_tready is held at 1.
- Assertions for the verification bench:
  - occupancy never exceeds DEPTH.
  - No push when occupancy==DEPTH.

Test Plan:
- Reset then idle: ack=0 in the reset cycle and =1 in the first cycle after; m_tvalid=0, occupancy=0, rx_count=0.
- Single word 0xDEADBEEF pushed with m_tready=1: m_tvalid=1 and m_tdata=0xDEADBEEF one cycle later; popped the next edge; occupancy returns to 0; rx_count=1.
- Fill with m_tready=0 using vld held 1 and words 0..N, DEPTH=16, AF_MARGIN=1: ack drops after occupancy reaches 15; exactly 15 words accepted; m_tdata stays 0 throughout the stall.
- Drain the full block with m_tready=1: outputs appear in order 0..14 on consecutive cycles; ack reasserts once occupancy<15.
- Streaming with vld=1 and m_tready=1 for 100 cycles of incrementing data: 1 word/cycle, occupancy constant, rx_count=100, order preserved across pointer wrap.
- Random vld and m_tready (~50% each, 10k cycles) with reset pulsed mid-run at cycle 5000:
  - The scoreboard matches all words before and after the reset.
  - Post-reset occupancy=0 and rx_count restarts from 0.
  - No word accepted before the reset appears after it.
